// File: rtl/acorn_pkg.sv
// ACORN-128 shared definitions: widths, decrypt FSM encoding, keystream taps
// and the maj/ch boolean helpers. The encryption, decryption and tag stages
// all use these.
package acorn_pkg;

   localparam int unsigned ACORN_STATE_W  = 293;
   localparam int unsigned ACORN_PAD_BITS = 256;
   localparam int unsigned ACORN_PAD_HALF = ACORN_PAD_BITS / 2;
   localparam int unsigned ACORN_CNT_W    = 12;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_DATA,
      DEC_PAD_A,
      DEC_PAD_B
   } dec_fsm_e;

   // Keystream tap positions
   localparam int unsigned KS_LIN0  = 12;
   localparam int unsigned KS_LIN1  = 154;
   localparam int unsigned KS_MAJ_X = 235;
   localparam int unsigned KS_MAJ_Y = 61;
   localparam int unsigned KS_MAJ_Z = 193;
   localparam int unsigned KS_CH_X  = 230;
   localparam int unsigned KS_CH_Y  = 111;
   localparam int unsigned KS_CH_Z  = 66;

   function automatic logic acorn_maj(input logic x, input logic y, input logic z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic acorn_ch(input logic x, input logic y, input logic z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic acorn_ks(input logic [ACORN_STATE_W-1:0] s);
      return s[KS_LIN0] ^ s[KS_LIN1]
           ^ acorn_maj(s[KS_MAJ_X], s[KS_MAJ_Y], s[KS_MAJ_Z])
           ^ acorn_ch(s[KS_CH_X], s[KS_CH_Y], s[KS_CH_Z]);
   endfunction

endpackage

// File: rtl/state_update128.sv
// One ACORN-128 state step (combinational).
//   ca_i, cb_i : control bits gating s[196] and the keystream into the feedback
//   m_i        : message bit absorbed into the new top bit
//   state_i    : current 293-bit state
//   state_o    : state after the LFSR updates, feedback and shift
module state_update128
   import acorn_pkg::*;
(
   input  logic                     ca_i,
   input  logic                     cb_i,
   input  logic                     m_i,
   input  logic [ACORN_STATE_W-1:0] state_i,
   output logic [ACORN_STATE_W-1:0] state_o
);

   logic [ACORN_STATE_W-1:0] s;
   logic                     f;

   always_comb begin
      s = state_i;
      // Six LFSR taps updated in place; each reads only positions not yet
      // touched, so the order reproduces the reference sequential update.
      s[289] = s[289] ^ s[235] ^ s[230];
      s[230] = s[230] ^ s[196] ^ s[193];
      s[193] = s[193] ^ s[160] ^ s[154];
      s[154] = s[154] ^ s[111] ^ s[107];
      s[107] = s[107] ^ s[66]  ^ s[61];
      s[61]  = s[61]  ^ s[23]  ^ s[0];
      f = s[0] ^ ~s[107] ^ acorn_maj(s[244], s[23], s[160])
        ^ (ca_i & s[196]) ^ (cb_i & acorn_ks(s)) ^ m_i;
      state_o = {f, s[ACORN_STATE_W-1:1]};
   end

endmodule

// File: rtl/decrypt_process.sv
// ACORN-128 decryption stage. Captures the post-AD state and a ciphertext
// block on start, recovers one plaintext bit per clock while absorbing it,
// then runs the two 128-step padding halves.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   start     : request, sampled only when idle
//   state_in  : post-AD state, captured at start
//   ct_in     : ciphertext block, bit 0 first, captured at start
//   pt_out    : recovered plaintext, bit i written at data step i
//   state_out : working state, final while done=1
//   busy      : high from capture until the final step
//   done      : one-cycle pulse after the final step
module decrypt_process
   import acorn_pkg::*;
#(
   parameter int unsigned MSG_BITS = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ACORN_STATE_W-1:0] state_in,
   input  logic [MSG_BITS-1:0]      ct_in,
   output logic [MSG_BITS-1:0]      pt_out,
   output logic [ACORN_STATE_W-1:0] state_out,
   output logic                     busy,
   output logic                     done
);

   localparam logic [ACORN_CNT_W-1:0] DATA_LAST = ACORN_CNT_W'(MSG_BITS - 1);
   localparam logic [ACORN_CNT_W-1:0] PAD_LAST  = ACORN_CNT_W'(ACORN_PAD_HALF - 1);

   dec_fsm_e                 fsm_q, fsm_d;
   logic [ACORN_CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACORN_STATE_W-1:0] state_q, state_d;
   logic [MSG_BITS-1:0]      ct_q, ct_d;
   logic [MSG_BITS-1:0]      pt_q, pt_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic                     su_m, su_ca;
   logic [ACORN_STATE_W-1:0] su_next;
   logic                     ks, ct_bit, p;

   state_update128 u_step (
      .ca_i    (su_ca),
      .cb_i    (1'b0),
      .m_i     (su_m),
      .state_i (state_q),
      .state_o (su_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= DEC_IDLE;
         cnt_q   <= '0;
         state_q <= '0;
         ct_q    <= '0;
         pt_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         ct_q    <= ct_d;
         pt_q    <= pt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      ct_d    = ct_q;
      pt_d    = pt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      su_m    = 1'b0;
      su_ca   = 1'b0;
      ks      = acorn_ks(state_q);
      ct_bit  = 1'b0;
      p       = 1'b0;

      case (fsm_q)
         DEC_IDLE: begin
            if (start) begin
               state_d = state_in;
               ct_d    = ct_in;
               pt_d    = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               fsm_d   = DEC_DATA;
            end
         end
         DEC_DATA: begin
            // Compare-based bit select keeps the index within MSG_BITS-1
            for (int unsigned i = 0; i < MSG_BITS; i++) begin
               if (cnt_q == ACORN_CNT_W'(i)) ct_bit = ct_q[i];
            end
            p = ct_bit ^ ks;
            for (int unsigned i = 0; i < MSG_BITS; i++) begin
               if (cnt_q == ACORN_CNT_W'(i)) pt_d[i] = p;
            end
            su_m    = p;
            su_ca   = 1'b1;
            state_d = su_next;
            if (cnt_q == DATA_LAST) begin
               cnt_d = '0;
               fsm_d = DEC_PAD_A;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DEC_PAD_A: begin
            su_m    = (cnt_q == '0);
            su_ca   = 1'b1;
            state_d = su_next;
            if (cnt_q == PAD_LAST) begin
               cnt_d = '0;
               fsm_d = DEC_PAD_B;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DEC_PAD_B: begin
            state_d = su_next;
            if (cnt_q == PAD_LAST) begin
               cnt_d  = '0;
               fsm_d  = DEC_IDLE;
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: fsm_d = DEC_IDLE;
      endcase
   end

   assign pt_out    = pt_q;
   assign state_out = state_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_decrypt_process.sv
module tb_decrypt_process;

   localparam int MB = 128;
   localparam int SW = 293;
   localparam int RUN_LEN = MB + 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [SW-1:0] state_in;
   logic [MB-1:0] ct_in;
   logic [MB-1:0] pt_out;
   logic [SW-1:0] state_out;
   logic          busy, done;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   decrypt_process #(.MSG_BITS(MB)) dut (
      .clk(clk), .rst(rst), .start(start), .state_in(state_in), .ct_in(ct_in),
      .pt_out(pt_out), .state_out(state_out), .busy(busy), .done(done)
   );

   // ---------------- reference model (algorithm level) ----------------
   function automatic logic m_maj(logic x, logic y, logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   function automatic logic m_ks(logic [SW-1:0] s);
      return s[12] ^ s[154] ^ m_maj(s[235], s[61], s[193]) ^ (s[230] ? s[111] : s[66]);
   endfunction

   function automatic logic [SW-1:0] m_step(logic [SW-1:0] s, logic m, logic ca, logic cb);
      logic [SW-1:0] t;
      logic f;
      t = s;
      t[289] = s[289] ^ s[235] ^ s[230];
      t[230] = s[230] ^ s[196] ^ s[193];
      t[193] = s[193] ^ s[160] ^ s[154];
      t[154] = s[154] ^ s[111] ^ s[107];
      t[107] = s[107] ^ s[66] ^ s[61];
      t[61]  = s[61] ^ s[23] ^ s[0];
      f = t[0] ^ ~t[107] ^ m_maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & m_ks(t)) ^ m;
      return {f, t[SW-1:1]};
   endfunction

   function automatic logic [SW-1:0] m_pad(logic [SW-1:0] s, logic cb);
      for (int j = 0; j < 256; j++) s = m_step(s, j == 0, j < 128, cb);
      return s;
   endfunction

   function automatic void m_decrypt(input logic [SW-1:0] st, input logic [MB-1:0] ct,
                                     output logic [MB-1:0] pt, output logic [SW-1:0] fs);
      logic [SW-1:0] s;
      s = st;
      for (int i = 0; i < MB; i++) begin
         pt[i] = ct[i] ^ m_ks(s);
         s = m_step(s, pt[i], 1'b1, 1'b0);
      end
      fs = m_pad(s, 1'b0);
   endfunction

   function automatic void m_encrypt(input logic [SW-1:0] st, input logic [MB-1:0] pt,
                                     output logic [MB-1:0] ct, output logic [SW-1:0] fs);
      logic [SW-1:0] s;
      s = st;
      for (int i = 0; i < MB; i++) begin
         ct[i] = pt[i] ^ m_ks(s);
         s = m_step(s, pt[i], 1'b1, 1'b0);
      end
      fs = m_pad(s, 1'b0);
   endfunction

   // Key/IV load and 1792-step init, then 16-byte AD and its padding
   function automatic logic [SW-1:0] m_post_ad(logic [127:0] key, logic [127:0] iv);
      logic [SW-1:0] s;
      logic [127:0]  ad;
      logic          m;
      s = '0;
      for (int i = 0; i < 1792; i++) begin
         if (i < 128)       m = key[i];
         else if (i < 256)  m = iv[i-128];
         else if (i == 256) m = ~key[0];
         else               m = key[i % 128];
         s = m_step(s, m, 1'b1, 1'b1);
      end
      for (int k = 0; k < 16; k++) ad[8*k +: 8] = 8'(k);
      for (int i = 0; i < 128; i++) s = m_step(s, ad[i], 1'b1, 1'b1);
      return m_pad(s, 1'b1);
   endfunction

   function automatic logic [SW-1:0] rand_state();
      logic [319:0] r;
      for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
      return r[SW-1:0];
   endfunction

   function automatic logic [MB-1:0] rand_ct();
      logic [MB-1:0] r;
      for (int k = 0; k < MB/32; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic run_txn(input logic [SW-1:0] st, input logic [MB-1:0] ct,
                          output logic [MB-1:0] pt, output logic [SW-1:0] fs,
                          output int lat, output int busy_cyc);
      @(negedge clk);
      state_in = st; ct_in = ct; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; busy_cyc = 0;
      while (!done && lat < 1000) begin
         if (busy) busy_cyc++;
         @(posedge clk); #1;
         lat++;
      end
      pt = pt_out; fs = state_out;
   endtask

   typedef struct {
      string         name;
      logic [SW-1:0] st;
      logic [MB-1:0] ct;
      logic [MB-1:0] exp_pt;
      logic [SW-1:0] exp_st;
   } vec_t;

   initial begin
      vec_t          tbl[$];
      vec_t          v;
      logic [127:0]  KEY, IV, PT;
      logic [SW-1:0] post_ad, enc_final, fs, fs3, st_rand;
      logic [MB-1:0] ct_rt, ct_flip, pt, pt3;
      int            lat, bc, ndone, done_lat;

      KEY = 128'h000102030405060708090A0B0C0D0E0F;
      IV  = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
      PT  = 128'h0123456789ABCDEF0123456789ABCDEF;
      post_ad = m_post_ad(KEY, IV);
      m_encrypt(post_ad, PT, ct_rt, enc_final);
      ct_flip = ct_rt;
      ct_flip[5] = ~ct_flip[5];

      v.name = "zero"; v.st = '0; v.ct = '0;
      m_decrypt(v.st, v.ct, v.exp_pt, v.exp_st); tbl.push_back(v);
      v.name = "roundtrip"; v.st = post_ad; v.ct = ct_rt; v.exp_pt = PT; v.exp_st = enc_final;
      tbl.push_back(v);
      v.name = "flip5"; v.st = post_ad; v.ct = ct_flip;
      m_decrypt(v.st, v.ct, v.exp_pt, v.exp_st); tbl.push_back(v);
      for (int r = 0; r < 4; r++) begin
         v.name = $sformatf("rand%0d", r); v.st = rand_state(); v.ct = rand_ct();
         m_decrypt(v.st, v.ct, v.exp_pt, v.exp_st); tbl.push_back(v);
      end

      // Reset state
      rst = 1'b1; start = 1'b0; state_in = '0; ct_in = '0;
      #23;
      chk("reset_pt", pt_out, '0);
      chk("reset_state", state_out, '0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(negedge clk); rst = 1'b0;

      // Zero vector timing: latency, busy length, single-cycle done
      run_txn('0, '0, pt, fs, lat, bc);
      chk("zero_pt0", pt[0], 0);
      chk("zero_latency", lat, RUN_LEN);
      chk("zero_busy_cycles", bc, RUN_LEN);
      chk("zero_busy_at_done", busy, 0);
      @(posedge clk); #1;
      chk("zero_done_pulse_width", done, 0);

      // Table of vectors
      foreach (tbl[k]) begin
         run_txn(tbl[k].st, tbl[k].ct, pt, fs, lat, bc);
         chk({tbl[k].name, "_pt"}, pt, tbl[k].exp_pt);
         chk({tbl[k].name, "_state"}, fs, tbl[k].exp_st);
         chk({tbl[k].name, "_latency"}, lat, RUN_LEN);
         if (tbl[k].name == "flip5") begin pt3 = pt; fs3 = fs; end
      end

      // Flipped ct bit 5 against the plaintext
      chk("flip5_low_bits_same", (pt3 ^ PT) & 128'h1F, '0);
      chk("flip5_bit5_differs", pt3[5] ^ PT[5], 1);
      chk("flip5_state_differs", fs3 != enc_final, 1);

      // Asynchronous reset in the middle of the data phase
      @(negedge clk);
      state_in = post_ad; ct_in = ct_rt; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (60) @(posedge clk);
      #2; rst = 1'b1; #1;
      chk("midrst_pt", pt_out, '0);
      chk("midrst_state", state_out, '0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      @(negedge clk); rst = 1'b0;
      run_txn(post_ad, ct_rt, pt, fs, lat, bc);
      chk("after_rst_pt", pt, PT);
      chk("after_rst_state", fs, enc_final);
      chk("after_rst_latency", lat, RUN_LEN);

      // start held high: no restart, second run begins right after done
      @(negedge clk);
      state_in = post_ad; ct_in = ct_rt; start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!done && lat < 1000) begin @(posedge clk); #1; lat++; end
      chk("held_run1_latency", lat, RUN_LEN);
      chk("held_run1_pt", pt_out, PT);
      chk("held_run1_state", state_out, enc_final);
      @(posedge clk); #1;
      chk("held_run2_busy", busy, 1);
      lat = 0;
      while (!done && lat < 1000) begin @(posedge clk); #1; lat++; end
      start = 1'b0;
      chk("held_run2_latency", lat, RUN_LEN);
      chk("held_run2_pt", pt_out, PT);
      chk("held_run2_state", state_out, enc_final);
      @(posedge clk); #1;
      chk("held_stop_busy", busy, 0);

      // start pulsed while busy is ignored
      st_rand = rand_state();
      @(negedge clk);
      state_in = post_ad; ct_in = ct_rt; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      ndone = 0; done_lat = -1;
      for (int c = 1; c <= RUN_LEN + 30; c++) begin
         @(negedge clk);
         if (c == 200) begin state_in = st_rand; ct_in = rand_ct(); start = 1'b1; end
         else start = 1'b0;
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (done_lat < 0) begin done_lat = c; pt = pt_out; fs = state_out; end
         end
      end
      chk("busy_start_done_count", ndone, 1);
      chk("busy_start_latency", done_lat, RUN_LEN);
      chk("busy_start_pt", pt, PT);
      chk("busy_start_state", fs, enc_final);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
